// File: rtl/fifo_stream_reader.sv
// ============================================================================
//  Module   : fifo_stream_reader
//  Brief    : Pops a packet of cfg_len words from a first-word-fall-after FIFO
//             and presents them on a valid/ready stream via a 2-entry skid.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int BITS_WIDTH = 32,
    parameter int BITS_LEN   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  start,
    input  logic [BITS_LEN-1:0]   cfg_len,
    output logic                  busy,
    output logic                  done,
    input  logic [BITS_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [BITS_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [BITS_LEN-1:0]   r_len;
    logic [BITS_LEN-1:0]   r_pops_left;
    logic [BITS_LEN-1:0]   r_beat_cnt;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [BITS_WIDTH-1:0] r_buf0;
    logic [BITS_WIDTH-1:0] r_buf1;

    logic                  w_xfer;
    logic                  w_pop;
    logic [2:0]            w_pending;
    logic [1:0]            w_wr_idx;

    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_buf0;
    assign m_last    = m_valid && (r_beat_cnt == r_len - BITS_LEN'(1));
    assign busy      = r_busy;
    assign done      = r_done;

    assign w_xfer    = m_valid && m_ready;
    // Words held plus words still in flight, after this cycle's departure.
    assign w_pending = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_xfer};
    // Reset gates the pop so a word is never taken from the FIFO and then lost.
    assign w_pop     = !i_rst && (r_state == RUN) && (r_pops_left != '0)
                       && !fifo_empty && (w_pending < 3'd2);
    assign fifo_rd_en = w_pop;

    assign w_wr_idx  = r_occ - {1'b0, w_xfer};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= '0;
            r_pops_left <= '0;
            r_beat_cnt  <= '0;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_pop;
            r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_xfer};

            if (w_pop)
                r_pops_left <= r_pops_left - BITS_LEN'(1);
            if (w_xfer)
                r_beat_cnt <= r_beat_cnt + BITS_LEN'(1);

            // Head shifts out first; the arriving word lands behind what remains.
            if (w_xfer)
                r_buf0 <= r_buf1;
            if (r_inflight) begin
                if (w_wr_idx == 2'd0)
                    r_buf0 <= fifo_dout;
                else
                    r_buf1 <= fifo_dout;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            r_len       <= cfg_len;
                            r_pops_left <= cfg_len;
                            r_beat_cnt  <= '0;
                            r_state     <= RUN;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_pop && (r_pops_left == BITS_LEN'(1)))
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_xfer && m_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Brief    : Scoreboard bench for fifo_stream_reader with a queue-based FIFO
//             model, directed packets and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int W      = 32;
    localparam int L      = 16;
    localparam int N_RAND = 600;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         start;
    logic [L-1:0] cfg_len;
    logic         busy;
    logic         done;
    logic [W-1:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;

    fifo_stream_reader #(.BITS_WIDTH(W), .BITS_LEN(L)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] src_q[$];
    int           xcyc_q[$];
    int           rd_cyc_q[$];

    int errors     = 0;
    int checks     = 0;
    int pops_total = 0;
    int xfer_total = 0;
    int done_total = 0;
    int cyc        = 0;
    int feed_pct   = 100;
    int ready_mode = 1;     // 0: hold low, 1: hold high, 2: random
    bit pend_pop   = 1'b0;
    bit zl_flag    = 1'b0;
    bit exp_done_next = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: head of the stream must always equal the next expected beat.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst) begin
                exp_done_next = 1'b0;
                zl_flag       = 1'b0;
            end else begin
                if (done || exp_done_next)
                    chk("done_pulse", 64'(done), 64'(exp_done_next));
                if (done)
                    done_total++;
                exp_done_next = zl_flag;
                zl_flag       = 1'b0;
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(m_valid), 64'd0);
                        if (m_ready) xfer_total++;
                    end else begin
                        chk("m_data", 64'(m_data), 64'(exp_q[0].d));
                        chk("m_last", 64'(m_last), 64'(exp_q[0].l));
                        if (m_ready) begin
                            if (exp_q[0].l) exp_done_next = 1'b1;
                            void'(exp_q.pop_front());
                            xfer_total++;
                            xcyc_q.push_back(cyc);
                        end
                    end
                end else if (m_last) begin
                    chk("m_last_without_valid", 64'(m_last), 64'd0);
                end
            end
        end
    end

    // One clock of stimulus; the FIFO model delivers a popped word the cycle after rd_en.
    task automatic cycle(input bit s = 1'b0, input logic [L-1:0] len = '0, input bit r = 1'b0);
        @(negedge i_clk);
        i_rst = r;
        if (pend_pop) begin
            pend_pop = 1'b0;
            if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        end
        if (src_q.size() != 0 && int'($urandom_range(0, 99)) < feed_pct)
            fifo_q.push_back(src_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        start      = s;
        cfg_len    = len;
        if (s && len == '0) zl_flag = 1'b1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (fifo_empty) chk("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
        if (!r) chk("outstanding_le_2", 64'((pops_total - xfer_total) <= 2), 64'd1);
        if (fifo_rd_en) begin
            pend_pop = 1'b1;
            pops_total++;
            rd_cyc_q.push_back(cyc);
        end
        #2;
    endtask

    task automatic load_pkt(input int len, input bit preload, input bit fixed);
        logic [W-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = fixed ? W'(32'h10 + i) : W'($urandom());
            exp_q.push_back('{d, (i == len - 1)});
            if (preload) fifo_q.push_back(d);
            else         src_q.push_back(d);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int base;
        int n;
        base = done_total;
        n    = 0;
        while (done_total == base && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 64'(done_total - base), 64'd1);
        chk({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"},    64'(busy),       64'd0);
        chk({name, "_done"},    64'(done),       64'd0);
        chk({name, "_rd_en"},   64'(fifo_rd_en), 64'd0);
        chk({name, "_m_valid"}, 64'(m_valid),    64'd0);
        chk({name, "_m_last"},  64'(m_last),     64'd0);
        chk({name, "_m_data"},  64'(m_data),     64'd0);
    endtask

    initial begin
        int n;
        int base;
        int len;

        i_rst = 1'b1; start = 1'b0; cfg_len = '0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0;

        // Power-up reset
        ready_mode = 0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk_idle_outputs("reset");

        // Preloaded 0x10..0x13, full-rate stream
        ready_mode = 1;
        feed_pct   = 100;
        load_pkt(4, 1'b1, 1'b1);
        xcyc_q.delete();
        rd_cyc_q.delete();
        cycle(1'b1, L'(4));
        wait_done("t4_done", 50);
        chk("t4_rd_count", 64'(rd_cyc_q.size()), 64'd4);
        chk("t4_rd_span", (rd_cyc_q.size() == 4) ? 64'(rd_cyc_q[3] - rd_cyc_q[0]) : 64'hFFFF, 64'd3);
        chk("t4_beat_span", (xcyc_q.size() == 4) ? 64'(xcyc_q[3] - xcyc_q[0]) : 64'hFFFF, 64'd3);

        // Downstream stall right after the first beat appears; a start mid-packet is ignored
        ready_mode = 0;
        load_pkt(8, 1'b1, 1'b1);
        rd_cyc_q.delete();
        cycle(1'b1, L'(8));
        cycle(1'b1, L'(3));
        n = 0;
        while (!m_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("t8_first_valid", 64'(m_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t8_stall_valid", 64'(m_valid), 64'd1);
            chk("t8_stall_data", 64'(m_data), 64'h10);
        end
        chk("t8_pops_in_stall", 64'(rd_cyc_q.size() <= 2), 64'd1);
        ready_mode = 1;
        wait_done("t8_done", 80);

        // FIFO runs dry after two words, then refills
        feed_pct = 0;
        load_pkt(6, 1'b0, 1'b1);
        fifo_q.push_back(src_q.pop_front());
        fifo_q.push_back(src_q.pop_front());
        cycle(1'b1, L'(6));
        n    = 0;
        base = 0;
        while (base < 3 && n < 30) begin
            cycle();
            if (fifo_empty) base++;
            n++;
        end
        chk("t6_empty_cycles", 64'(base), 64'd3);
        feed_pct = 100;
        wait_done("t6_done", 60);

        // Zero-length packet
        base = done_total;
        rd_cyc_q.delete();
        cycle(1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t0_busy", 64'(busy), 64'd0);
            chk("t0_m_valid", 64'(m_valid), 64'd0);
        end
        chk("t0_done_count", 64'(done_total - base), 64'd1);
        chk("t0_no_pops", 64'(rd_cyc_q.size()), 64'd0);

        // Reset while beat 3 of 8 is presented
        ready_mode = 1;
        load_pkt(8, 1'b1, 1'b1);
        base = xfer_total;
        cycle(1'b1, L'(8));
        n = 0;
        while (xfer_total - base < 2 && n < 30) begin
            cycle();
            n++;
        end
        chk("t_rst_two_beats", 64'(xfer_total - base), 64'd2);
        base = done_total;
        ready_mode = 0;
        cycle(1'b0, '0, 1'b1);
        exp_q.delete();
        fifo_q.delete();
        src_q.delete();
        pend_pop   = 1'b0;
        pops_total = xfer_total;
        cycle();
        chk_idle_outputs("midrst");
        ready_mode = 1;
        load_pkt(2, 1'b1, 1'b1);
        cycle(1'b1, L'(2));
        wait_done("t_rst_len2_done", 30);
        chk("t_rst_single_done", 64'(done_total - base), 64'd1);

        // Randomized traffic
        for (int p = 0; p < N_RAND; p++) begin
            len        = int'($urandom_range(1, 64));
            ready_mode = 2;
            feed_pct   = int'($urandom_range(60, 100));
            load_pkt(len, 1'b0, 1'b0);
            cycle(1'b1, L'(len));
            wait_done("rand_done", len * 30 + 50);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
